// File: rtl/down_count_timer.sv
// down_count_timer: loadable down-counter with run/hold/done control and optional auto-reload
module down_count_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             auto_reload_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             done_o
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] count_ff;
  logic [WIDTH-1:0] reload_ff;
  logic zero;
  assign zero = count_ff == '0;
  // Outputs are forced low while reset is held so no tc pulse escapes on the reset edge
  assign count_o = rst ? '0 : count_ff;
  assign busy_o = !rst && state == RUN;
  assign tc_o = !rst && state == RUN && zero;
  assign done_o = !rst && state == DONE;
  // Control FSM: load beats stop, stop beats start; stop in RUN also suppresses the terminal action
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count_ff <= '0;
      reload_ff <= '0;
    end else if (load_i) begin
      count_ff <= load_val_i;
      reload_ff <= load_val_i;
      if (state == DONE) state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) state <= RUN;
        RUN:
          if (stop_i) state <= HOLD;
          else if (!zero) count_ff <= count_ff - 1'b1;
          else if (auto_reload_i) count_ff <= reload_ff;
          else state <= DONE;
        HOLD:
          if (stop_i) state <= IDLE;
          else if (start_i) state <= RUN;
        default:
          if (start_i) begin
            count_ff <= reload_ff;
            state <= RUN;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_down_count_timer.sv
// tb_down_count_timer: directed scenario checks for down_count_timer
module tb_down_count_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_i = 1'b0;
  logic [3:0] load_val_i = 4'h0;
  logic start_i = 1'b0;
  logic stop_i = 1'b0;
  logic auto_reload_i = 1'b0;
  logic [3:0] count_o;
  logic busy_o, tc_o, done_o;
  int checks = 0;
  int failures = 0;

  down_count_timer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .load_i(load_i), .load_val_i(load_val_i),
    .start_i(start_i), .stop_i(stop_i), .auto_reload_i(auto_reload_i),
    .count_o(count_o), .busy_o(busy_o), .tc_o(tc_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Stimulus word: {load_val, load, stop, start, auto_reload, rst}; outputs observed 1ns after the edge
  task automatic step(input logic [8:0] s);
    {load_val_i, load_i, stop_i, start_i, auto_reload_i, rst} = s;
    @(posedge clk);
    #1;
  endtask

  // Table rows are {stimulus[8:0], expected {count, busy, tc, done}}
  task automatic test_reset();
    logic [15:0] v [2] = '{
      {4'h0, 5'b00001, 4'h0, 3'b000},
      {4'h0, 5'b00000, 4'h0, 3'b000}
    };
    for (int i = 0; i < 2; i++) begin
      step(v[i][15:7]);
      checks++;
      if ({count_o, busy_o, tc_o, done_o} !== v[i][6:0]) begin
        failures++;
        $display("FAIL reset step %0d: got %h want %h", i, {count_o, busy_o, tc_o, done_o}, v[i][6:0]);
      end
    end
  endtask

  task automatic test_one_shot();
    logic [15:0] v [13] = '{
      {4'h3, 5'b10000, 4'h3, 3'b000},
      {4'h0, 5'b00100, 4'h3, 3'b100},
      {4'h0, 5'b00000, 4'h2, 3'b100},
      {4'h0, 5'b00000, 4'h1, 3'b100},
      {4'h0, 5'b00000, 4'h0, 3'b110},
      {4'h0, 5'b00000, 4'h0, 3'b001},
      {4'h0, 5'b00000, 4'h0, 3'b001},
      {4'h1, 5'b10000, 4'h1, 3'b000},
      {4'h0, 5'b00100, 4'h1, 3'b100},
      {4'h0, 5'b00000, 4'h0, 3'b110},
      {4'h0, 5'b01000, 4'h0, 3'b000},
      {4'h0, 5'b00100, 4'h0, 3'b110},
      {4'h0, 5'b00000, 4'h0, 3'b001}
    };
    for (int i = 0; i < 13; i++) begin
      step(v[i][15:7]);
      checks++;
      if ({count_o, busy_o, tc_o, done_o} !== v[i][6:0]) begin
        failures++;
        $display("FAIL one_shot step %0d: got %h want %h", i, {count_o, busy_o, tc_o, done_o}, v[i][6:0]);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [15:0] v [16] = '{
      {4'h2, 5'b10010, 4'h2, 3'b000},
      {4'h0, 5'b00110, 4'h2, 3'b100},
      {4'h0, 5'b00010, 4'h1, 3'b100},
      {4'h0, 5'b00010, 4'h0, 3'b110},
      {4'h0, 5'b00010, 4'h2, 3'b100},
      {4'h0, 5'b00010, 4'h1, 3'b100},
      {4'h0, 5'b00010, 4'h0, 3'b110},
      {4'h0, 5'b00010, 4'h2, 3'b100},
      {4'h0, 5'b01010, 4'h2, 3'b000},
      {4'h0, 5'b01010, 4'h2, 3'b000},
      {4'h0, 5'b10010, 4'h0, 3'b000},
      {4'h0, 5'b00110, 4'h0, 3'b110},
      {4'h0, 5'b00010, 4'h0, 3'b110},
      {4'h0, 5'b00010, 4'h0, 3'b110},
      {4'h0, 5'b01010, 4'h0, 3'b000},
      {4'h0, 5'b01010, 4'h0, 3'b000}
    };
    for (int i = 0; i < 16; i++) begin
      step(v[i][15:7]);
      checks++;
      if ({count_o, busy_o, tc_o, done_o} !== v[i][6:0]) begin
        failures++;
        $display("FAIL auto_reload step %0d: got %h want %h", i, {count_o, busy_o, tc_o, done_o}, v[i][6:0]);
      end
    end
  endtask

  task automatic test_pause_resume();
    logic [15:0] v [13] = '{
      {4'h9, 5'b10000, 4'h9, 3'b000},
      {4'h0, 5'b00100, 4'h9, 3'b100},
      {4'h0, 5'b00000, 4'h8, 3'b100},
      {4'h0, 5'b00000, 4'h7, 3'b100},
      {4'h0, 5'b00000, 4'h6, 3'b100},
      {4'h0, 5'b00000, 4'h5, 3'b100},
      {4'h0, 5'b01000, 4'h5, 3'b000},
      {4'h0, 5'b00000, 4'h5, 3'b000},
      {4'h0, 5'b00100, 4'h5, 3'b100},
      {4'h0, 5'b00000, 4'h4, 3'b100},
      {4'h0, 5'b00000, 4'h3, 3'b100},
      {4'h0, 5'b01000, 4'h3, 3'b000},
      {4'h0, 5'b01000, 4'h3, 3'b000}
    };
    for (int i = 0; i < 13; i++) begin
      step(v[i][15:7]);
      checks++;
      if ({count_o, busy_o, tc_o, done_o} !== v[i][6:0]) begin
        failures++;
        $display("FAIL pause_resume step %0d: got %h want %h", i, {count_o, busy_o, tc_o, done_o}, v[i][6:0]);
      end
    end
  endtask

  task automatic test_priority();
    logic [15:0] v [9] = '{
      {4'h8, 5'b10000, 4'h8, 3'b000},
      {4'h0, 5'b00100, 4'h8, 3'b100},
      {4'h0, 5'b00000, 4'h7, 3'b100},
      {4'h0, 5'b00000, 4'h6, 3'b100},
      {4'hA, 5'b11100, 4'hA, 3'b100},
      {4'h0, 5'b00000, 4'h9, 3'b100},
      {4'h0, 5'b00000, 4'h8, 3'b100},
      {4'h0, 5'b01000, 4'h8, 3'b000},
      {4'h0, 5'b01000, 4'h8, 3'b000}
    };
    for (int i = 0; i < 9; i++) begin
      step(v[i][15:7]);
      checks++;
      if ({count_o, busy_o, tc_o, done_o} !== v[i][6:0]) begin
        failures++;
        $display("FAIL priority step %0d: got %h want %h", i, {count_o, busy_o, tc_o, done_o}, v[i][6:0]);
      end
    end
  endtask

  task automatic test_edge_values();
    logic [15:0] v [8] = '{
      {4'h0, 5'b10000, 4'h0, 3'b000},
      {4'h0, 5'b00100, 4'h0, 3'b110},
      {4'h0, 5'b00000, 4'h0, 3'b001},
      {4'h0, 5'b01000, 4'h0, 3'b001},
      {4'h0, 5'b00100, 4'h0, 3'b110},
      {4'h0, 5'b00000, 4'h0, 3'b001},
      {4'hF, 5'b10000, 4'hF, 3'b000},
      {4'h0, 5'b00100, 4'hF, 3'b100}
    };
    logic [15:0] w [4] = '{
      {4'h0, 5'b00000, 4'h0, 3'b001},
      {4'h0, 5'b00100, 4'hF, 3'b100},
      {4'h0, 5'b01000, 4'hF, 3'b000},
      {4'h0, 5'b01000, 4'hF, 3'b000}
    };
    logic [6:0] exp;
    for (int i = 0; i < 8; i++) begin
      step(v[i][15:7]);
      checks++;
      if ({count_o, busy_o, tc_o, done_o} !== v[i][6:0]) begin
        failures++;
        $display("FAIL edge step %0d: got %h want %h", i, {count_o, busy_o, tc_o, done_o}, v[i][6:0]);
      end
    end
    for (int k = 1; k <= 15; k++) begin
      step(9'b0);
      exp = {4'(15 - k), 1'b1, 1'(k == 15), 1'b0};
      checks++;
      if ({count_o, busy_o, tc_o, done_o} !== exp) begin
        failures++;
        $display("FAIL edge countdown %0d: got %h want %h", k, {count_o, busy_o, tc_o, done_o}, exp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(w[i][15:7]);
      checks++;
      if ({count_o, busy_o, tc_o, done_o} !== w[i][6:0]) begin
        failures++;
        $display("FAIL edge_done step %0d: got %h want %h", i, {count_o, busy_o, tc_o, done_o}, w[i][6:0]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] v [9] = '{
      {4'h6, 5'b10000, 4'h6, 3'b000},
      {4'h0, 5'b00100, 4'h6, 3'b100},
      {4'h0, 5'b00000, 4'h5, 3'b100},
      {4'h0, 5'b00000, 4'h4, 3'b100},
      {4'h0, 5'b00101, 4'h0, 3'b000},
      {4'h0, 5'b00100, 4'h0, 3'b110},
      {4'h0, 5'b00000, 4'h0, 3'b001},
      {4'h0, 5'b10010, 4'h0, 3'b000},
      {4'h0, 5'b00110, 4'h0, 3'b110}
    };
    for (int i = 0; i < 9; i++) begin
      step(v[i][15:7]);
      checks++;
      if ({count_o, busy_o, tc_o, done_o} !== v[i][6:0]) begin
        failures++;
        $display("FAIL reset_mid_run step %0d: got %h want %h", i, {count_o, busy_o, tc_o, done_o}, v[i][6:0]);
      end
    end
    start_i = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({count_o, busy_o, tc_o, done_o} !== 7'h00) begin
      failures++;
      $display("FAIL reset_held_at_tc: got %h want %h", {count_o, busy_o, tc_o, done_o}, 7'h00);
    end
    step(9'b000000011);
    checks++;
    if ({count_o, busy_o, tc_o, done_o} !== 7'h00) begin
      failures++;
      $display("FAIL reset_edge_at_tc: got %h want %h", {count_o, busy_o, tc_o, done_o}, 7'h00);
    end
    step(9'b000000000);
    checks++;
    if ({count_o, busy_o, tc_o, done_o} !== 7'h00) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", {count_o, busy_o, tc_o, done_o}, 7'h00);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause_resume();
    test_priority();
    test_edge_values();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/down_count_timer.md
DOWN_COUNT_TIMER -- requirements
Module: down_count_timer

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the counter, the reload register and the load value.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_i  input  1  load strobe; captures load_val_i into the counter and the reload register.
REQ-005 load_val_i  input  WIDTH  value to load.
REQ-006 start_i  input  1  start or resume the countdown.
REQ-007 stop_i  input  1  pause (from RUN) or abort (from HOLD).
REQ-008 auto_reload_i  input  1  1 = reload and continue at terminal count; 0 = one-shot.
REQ-009 count_o  output  WIDTH  current counter value (registered).
REQ-010 busy_o  output  1  high while state is RUN.
REQ-011 tc_o  output  1  terminal-count indicator.
REQ-012 done_o  output  1  high while state is DONE.

Function
REQ-013 The block SHALL hold a WIDTH-bit counter count_ff, a WIDTH-bit reload register reload_ff, and a state register with the states IDLE, RUN, HOLD and DONE.
REQ-014 In any state, load_i=1 SHALL set count_ff and reload_ff to load_val_i on the next edge.
REQ-015 The priority of simultaneous controls SHALL be load_i > stop_i > start_i.
REQ-016 A load in IDLE, RUN or HOLD SHALL leave the state unchanged; a load in DONE SHALL move the state to IDLE.
REQ-017 IDLE: start_i SHALL move the state to RUN; count_ff holds; stop_i is ignored.
REQ-018 RUN with count_ff != 0: count_ff SHALL decrement by 1 each cycle, with no wrap below 0.
REQ-019 RUN with count_ff == 0 SHALL assert tc_o combinationally (tc_o = state==RUN && count_ff==0) for exactly that cycle.
REQ-020 RUN with count_ff == 0 and auto_reload_i=1: on the next edge count_ff SHALL take reload_ff and the state SHALL remain RUN.
REQ-021 RUN with count_ff == 0 and auto_reload_i=0: the state SHALL move to DONE and count_ff SHALL hold 0.
REQ-022 With auto_reload_i=1 and reload_ff == 0, tc_o SHALL assert every cycle while in RUN.
REQ-023 RUN: stop_i SHALL move the state to HOLD and freeze count_ff on that edge (no decrement), and SHALL suppress the terminal action of REQ-020/REQ-021 on that edge; tc_o is still asserted that cycle per REQ-019.
REQ-024 RUN: a load_i mid-count SHALL take effect on the next edge, and the countdown SHALL continue from load_val_i on the following cycle.
REQ-025 HOLD: count_ff SHALL hold; start_i SHALL move the state to RUN; stop_i SHALL move the state to IDLE with count_ff unchanged.
REQ-026 DONE: done_o=1; start_i SHALL set count_ff to reload_ff and move the state to RUN; stop_i is ignored.
REQ-027 In RUN, start_i SHALL be ignored.
REQ-028 auto_reload_i SHALL be sampled only in the RUN, count_ff==0 cycle.
REQ-029 All arithmetic SHALL be unsigned, modulo 2^WIDTH; no output SHALL go X/Z after reset.

Reset
REQ-030 rst=1 at a rising edge SHALL set count_ff=0, reload_ff=0 and state=IDLE, overriding all other inputs.
REQ-031 While in reset, count_o=0, busy_o=0, tc_o=0 and done_o=0.
REQ-032 Reset asserted mid-RUN SHALL abort the countdown in one cycle, with no tc_o pulse on that edge.

Verification
REQ-033 One-shot: load 3, auto_reload_i=0, start -> busy_o=1, count_o 3,2,1,0; tc_o=1 one cycle at 0; next cycle done_o=1, busy_o=0, count_o=0.
REQ-034 Auto-reload: load 2, auto_reload_i=1, start -> count_o 2,1,0,2,1,0,...; tc_o pulses every 3rd cycle; done_o stays 0.
REQ-035 Pause/resume/abort: load 9, start; at count_o=5 pulse stop_i -> count_o holds 5, busy_o=0; start_i -> continues 4,3; stop_i, then stop_i again -> IDLE, count_o=3.
REQ-036 Priority: in RUN at count 6, assert load_i (val 0xA), stop_i and start_i together -> count_o=0xA, state stays RUN, decrements to 9 next cycle.
REQ-037 Edge values: load 0 then start, auto_reload_i=0 -> tc_o=1 in first RUN cycle, then DONE; in DONE, start with reload_ff=0xF -> count_o=0xF, RUN.
REQ-038 Reset: rst during RUN at count 4 -> next edge count_o=0, IDLE, all flags 0; start without load -> tc_o pulse, then DONE.
